// File: rtl/munch_pkg.sv
// Shared types and constants for the munch animation sequencer:
// FSM state encoding, config register map and reset defaults.
package munch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } munch_state_e;

    localparam logic [1:0] ADDR_SPEED = 2'd0;
    localparam logic [1:0] ADDR_STEP  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam logic [7:0] RST_SPEED = 8'd0;
    localparam logic [7:0] RST_STEP  = 8'd1;
    localparam logic [7:0] RST_MASK  = 8'hFF;
    localparam logic [4:0] RST_CTRL  = 5'd0;

    localparam int CTRL_W      = 5;
    localparam int CTRL_DIR    = 0;
    localparam int CTRL_BOUNCE = 1;

    function automatic logic [2:0] ctrl_color(input logic [CTRL_W-1:0] ctrl);
        return ctrl[4:2];
    endfunction

endpackage

// File: rtl/munch_frame_div.sv
// Frame prescaler: counts qualifying frame pulses and ticks once every speed+1 of them.
module munch_frame_div
    import munch_pkg::*;
#(
    parameter int T_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           count_en,
    input  logic           clear,
    input  logic [T_W-1:0] speed,
    output logic           tick
);

    logic [T_W-1:0] count_r;
    logic           hit_s;

    // >= keeps the counter bounded if speed is lowered below the current count
    assign hit_s = (count_r >= speed);
    assign tick  = count_en && hit_s;

    // frame counter, cleared on RUN entry and held whenever not enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_en) begin
            count_r <= hit_s ? '0 : count_r + {{(T_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/munch_sequencer.sv
// Munch animation sequencer: shadowed config, run/pause FSM and threshold stepping.
// Optional bounce mode is compiled in with the MUNCH_BOUNCE_EN macro.
module munch_sequencer
    import munch_pkg::*;
#(
    parameter int T_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_start,
    input  logic           run,
    input  logic           step,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [1:0]     cfg_addr,
    input  logic [7:0]     cfg_data,
    output logic [T_W-1:0] t,
    output logic [7:0]     xor_mask,
    output logic [2:0]     color_idx,
    output logic           update,
    output logic [1:0]     state
);

    munch_state_e    state_r, state_next_s;
    logic            cfg_ready_r;
    logic            wr_s;

    logic [T_W-1:0]  speed_sh_r, step_sh_r, speed_act_r, step_act_r;
    logic [7:0]      mask_sh_r, mask_act_r;
    logic [CTRL_W-1:0] ctrl_sh_r, ctrl_act_r, ctrl_act_next_s;

    logic [T_W-1:0]  t_r, t_next_s;
    logic [2:0]      color_r, color_next_s;
    logic            update_r;
    logic            step_latch_r, step_latch_next_s;

    logic            div_tick_s, div_clear_s, div_en_s;
    logic [T_W-1:0]  step_eff_s, sum_s, diff_s, wrap_t_s;
    logic            carry_s, borrow_s, wrap_hit_s, dir_down_s;
    logic            advance_s, color_inc_s, flip_s;
    logic            unused_s;

    assign wr_s     = cfg_valid && cfg_ready_r;
    assign unused_s = ctrl_act_r[CTRL_BOUNCE];

    // ready drops for exactly one cycle after each accepted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready_r <= 1'b0;
        end else begin
            cfg_ready_r <= !wr_s;
        end
    end

    // shadow registers take host writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_sh_r <= T_W'(RST_SPEED);
            step_sh_r  <= T_W'(RST_STEP);
            mask_sh_r  <= RST_MASK;
            ctrl_sh_r  <= RST_CTRL;
        end else if (wr_s) begin
            case (cfg_addr)
                ADDR_SPEED: speed_sh_r <= T_W'(cfg_data);
                ADDR_STEP:  step_sh_r  <= T_W'(cfg_data);
                ADDR_MASK:  mask_sh_r  <= cfg_data;
                ADDR_CTRL:  ctrl_sh_r  <= cfg_data[CTRL_W-1:0];
                default:    mask_sh_r  <= mask_sh_r;
            endcase
        end
    end

    // active config copies shadow at frame start; same-edge shadow writes wait a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_act_r <= T_W'(RST_SPEED);
            step_act_r  <= T_W'(RST_STEP);
            mask_act_r  <= RST_MASK;
            ctrl_act_r  <= RST_CTRL;
        end else if (frame_start) begin
            speed_act_r <= speed_sh_r;
            step_act_r  <= step_sh_r;
            mask_act_r  <= mask_sh_r;
            ctrl_act_r  <= ctrl_act_next_s;
        end
    end

    // FSM next state: moves only on frame start
    always_comb begin
        state_next_s = state_r;
        if (frame_start) begin
            case (state_r)
                ST_IDLE:  state_next_s = run ? ST_RUN : ST_IDLE;
                ST_RUN:   state_next_s = run ? ST_RUN : ST_PAUSE;
                ST_PAUSE: state_next_s = run ? ST_RUN : ST_PAUSE;
                default:  state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    assign div_en_s    = frame_start && (state_r == ST_RUN);
    assign div_clear_s = frame_start && (state_next_s == ST_RUN) && (state_r != ST_RUN);

    munch_frame_div #(.T_W(T_W)) u_frame_div (
        .clk      (clk),
        .rst      (rst),
        .count_en (div_en_s),
        .clear    (div_clear_s),
        .speed    (speed_act_r),
        .tick     (div_tick_s)
    );

    // pause-mode step latch: collapses any number of pulses into one advance
    always_comb begin
        step_latch_next_s = 1'b0;
        if (state_r == ST_PAUSE) begin
            step_latch_next_s = frame_start ? 1'b0 : (step_latch_r || step);
        end else begin
            step_latch_next_s = 1'b0;
        end
    end

    // advance arithmetic, using the config that was active before this edge
    always_comb begin
        step_eff_s = (step_act_r == '0) ? {{(T_W-1){1'b0}}, 1'b1} : step_act_r;
        {carry_s, sum_s} = {1'b0, t_r} + {1'b0, step_eff_s};
        diff_s     = t_r - step_eff_s;
        borrow_s   = (t_r < step_eff_s);
        dir_down_s = ctrl_act_r[CTRL_DIR];
        wrap_t_s   = dir_down_s ? diff_s : sum_s;
        wrap_hit_s = dir_down_s ? borrow_s : carry_s;
        advance_s  = frame_start &&
                     (div_tick_s || ((state_r == ST_PAUSE) && (step_latch_r || step)));
    end

    // next threshold, wrap/flip detection and colour stepping
    always_comb begin
        t_next_s     = t_r;
        color_inc_s  = 1'b0;
        flip_s       = 1'b0;
        if (advance_s) begin
`ifdef MUNCH_BOUNCE_EN
            if (ctrl_act_r[CTRL_BOUNCE]) begin
                if (!dir_down_s) begin
                    t_next_s = carry_s ? '1 : sum_s;
                    flip_s   = carry_s;
                end else begin
                    t_next_s = borrow_s ? '0 : diff_s;
                    flip_s   = borrow_s;
                end
                color_inc_s = flip_s;
            end else begin
                t_next_s    = wrap_t_s;
                color_inc_s = wrap_hit_s;
            end
`else
            t_next_s    = wrap_t_s;
            color_inc_s = wrap_hit_s;
`endif
        end else begin
            t_next_s = t_r;
        end

        ctrl_act_next_s = ctrl_sh_r;
        if (flip_s) begin
            ctrl_act_next_s[CTRL_DIR] = ~dir_down_s;
        end else begin
            ctrl_act_next_s[CTRL_DIR] = ctrl_sh_r[CTRL_DIR];
        end

        color_next_s = color_r;
        if (frame_start && (ctrl_color(ctrl_sh_r) != ctrl_color(ctrl_act_r))) begin
            color_next_s = ctrl_color(ctrl_sh_r);
        end else if (color_inc_s) begin
            color_next_s = color_r + 3'd1;
        end else begin
            color_next_s = color_r;
        end
    end

    // state, threshold, colour and update pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            t_r          <= '0;
            color_r      <= 3'd0;
            update_r     <= 1'b0;
            step_latch_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            t_r          <= t_next_s;
            color_r      <= color_next_s;
            update_r     <= (t_next_s != t_r);
            step_latch_r <= step_latch_next_s;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign t         = t_r;
    assign xor_mask  = mask_act_r;
    assign color_idx = color_r;
    assign update    = update_r;
    assign state     = state_r;

endmodule

// File: tb/tb_munch_sequencer.sv
// Directed self-checking bench for munch_sequencer; bounce checks follow MUNCH_BOUNCE_EN.
module tb_munch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic [7:0] t;
    logic [7:0] xor_mask;
    logic [2:0] color_idx;
    logic       update;
    logic [1:0] state;

    int n_assert = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    int upd_base = 0;

    munch_sequencer #(.T_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .run         (run),
        .step        (step),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .t           (t),
        .xor_mask    (xor_mask),
        .color_idx   (color_idx),
        .update      (update),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (update === 1'b1) upd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        int waited = 0;
        while (cfg_ready !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        chk("cfg_ready_before_write", {31'd0, cfg_ready}, 32'd1);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_ready_after_write", {31'd0, cfg_ready}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        run = 1'b0;
        step = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_t", {24'd0, t}, 32'd0);
        chk("rst_color", {29'd0, color_idx}, 32'd0);
        chk("rst_update", {31'd0, update}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_xor_mask", {24'd0, xor_mask}, 32'hFF);
        rst = 1'b0;
        tick();
        chk("cfg_ready_after_release", {31'd0, cfg_ready}, 32'd1);
    endtask

    initial begin
        // basic run: first frame enters RUN, then t=1, t=2 with two update pulses
        do_reset();
        run = 1'b1;
        upd_base = upd_cnt;
        frame();
        chk("run_state", {30'd0, state}, 32'd1);
        chk("run_t0", {24'd0, t}, 32'd0);
        frame();
        chk("run_t1", {24'd0, t}, 32'd1);
        frame();
        chk("run_t2", {24'd0, t}, 32'd2);
        chk("run_updates", upd_cnt - upd_base, 32'd2);

        // reset mid-run discards progress
        do_reset();

        // speed=2: advance every third frame once running
        cfg_write(2'd0, 8'd2);
        run = 1'b1;
        begin
            logic [7:0] exp_t [9] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
            for (int k = 0; k < 9; k++) begin
                frame();
                chk($sformatf("speed2_f%0d", k + 1), {24'd0, t}, {24'd0, exp_t[k]});
            end
        end

        // wrap upward: step 16 from 240 -> 0 and colour +1
        do_reset();
        cfg_write(2'd1, 8'd16);
        run = 1'b1;
        frame();
        for (int k = 2; k <= 16; k++) frame();
        chk("wrap_t240", {24'd0, t}, 32'd240);
        chk("wrap_color0", {29'd0, color_idx}, 32'd0);
        frame();
        chk("wrap_t0", {24'd0, t}, 32'd0);
        chk("wrap_color1", {29'd0, color_idx}, 32'd1);

        // colour base load, then downward wrap increments from the base
        cfg_write(2'd3, 8'h14);
        frame();
        chk("base_color5", {29'd0, color_idx}, 32'd5);
        chk("base_t16", {24'd0, t}, 32'd16);
        cfg_write(2'd3, 8'h15);
        frame();
        chk("down_t32", {24'd0, t}, 32'd32);
        frame();
        chk("down_t16", {24'd0, t}, 32'd16);
        frame();
        chk("down_t0", {24'd0, t}, 32'd0);
        frame();
        chk("down_wrap_t240", {24'd0, t}, 32'd240);
        chk("down_wrap_color6", {29'd0, color_idx}, 32'd6);

        // bounce: climb to 250 with step 10, then step 16 with bounce selected
        do_reset();
        cfg_write(2'd1, 8'd10);
        run = 1'b1;
        frame();
        for (int k = 2; k <= 25; k++) frame();
        chk("ramp_t240", {24'd0, t}, 32'd240);
        cfg_write(2'd1, 8'd16);
        cfg_write(2'd3, 8'h02);
        frame();
        chk("ramp_t250", {24'd0, t}, 32'd250);
        frame();
`ifdef MUNCH_BOUNCE_EN
        chk("bounce_t255", {24'd0, t}, 32'd255);
        chk("bounce_color1", {29'd0, color_idx}, 32'd1);
        frame();
        chk("bounce_t239", {24'd0, t}, 32'd239);
        frame();
        chk("bounce_reup_t255", {24'd0, t}, 32'd255);
        chk("bounce_reup_color1", {29'd0, color_idx}, 32'd1);
        frame();
        chk("bounce_flip2_t255", {24'd0, t}, 32'd255);
        chk("bounce_flip2_color2", {29'd0, color_idx}, 32'd2);
`else
        chk("nobounce_t10", {24'd0, t}, 32'd10);
        chk("nobounce_color1", {29'd0, color_idx}, 32'd1);
`endif

        // pause: several step pulses give exactly one advance
        do_reset();
        run = 1'b1;
        frame();
        frame();
        chk("pause_pre_t1", {24'd0, t}, 32'd1);
        run = 1'b0;
        frame();
        chk("pause_state", {30'd0, state}, 32'd2);
        chk("pause_t2", {24'd0, t}, 32'd2);
        frame();
        chk("pause_hold_t2", {24'd0, t}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
        end
        chk("pause_no_early_adv", {24'd0, t}, 32'd2);
        frame();
        chk("pause_step_t3", {24'd0, t}, 32'd3);
        frame();
        chk("pause_once_t3", {24'd0, t}, 32'd3);
        run = 1'b1;
        frame();
        chk("resume_state", {30'd0, state}, 32'd1);

        // mask written on the frame-start cycle applies one frame later
        do_reset();
        cfg_addr    = 2'd2;
        cfg_data    = 8'h0F;
        cfg_valid   = 1'b1;
        frame_start = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        frame_start = 1'b0;
        chk("mask_fs_ready0", {31'd0, cfg_ready}, 32'd0);
        chk("mask_fs_still_ff", {24'd0, xor_mask}, 32'hFF);
        tick();
        tick();
        chk("mask_hold_ff", {24'd0, xor_mask}, 32'hFF);
        frame();
        chk("mask_applied_0f", {24'd0, xor_mask}, 32'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/munch_sequencer.md
MUNCH_SEQUENCER -- requirements
Module: munch_sequencer

Interface
REQ-001 SHALL have parameter T_W, default 8: width of threshold t and of speed/step fields.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-005 run  in  1  level; 1 requests animation, 0 requests pause.
REQ-006 step  in  1  one-cycle pulse; single advance while paused.
REQ-007 cfg_valid  in  1 / cfg_ready  out  1  config write handshake.
REQ-008 cfg_addr  in  2 / cfg_data  in  8  register address and data.
REQ-009 t  out  T_W  threshold driven to the munch pixel datapath.
REQ-010 xor_mask  out  8  mask applied to x^y by the datapath.
REQ-011 color_idx  out  3  palette index.
REQ-012 update  out  1  one-cycle pulse on the cycle t changes.
REQ-013 state  out  2  current FSM state, encoded IDLE=0, RUN=1, PAUSE=2.

Function
REQ-014 SHALL accept a write on cycles where cfg_valid&&cfg_ready; cfg_ready SHALL be 0 on the cycle after an accepted write, otherwise 1.
REQ-015 Registers: addr0 speed (advance every speed+1 frames); addr1 step (0 treated as 1); addr2 mask; addr3 ctrl[0]=dir (0 up), ctrl[1]=bounce, ctrl[4:2]=color base.
REQ-016 Writes SHALL land in shadow registers; shadow SHALL copy to active on each frame_start; xor_mask SHALL reflect active mask.
REQ-017 A write accepted on the frame_start cycle SHALL go to shadow only and become active at the following frame_start.
REQ-018 Advance decisions at a frame_start SHALL use the active config held before that edge.
REQ-019 FSM transitions occur only on frame_start: IDLE->RUN if run; RUN->PAUSE if !run; PAUSE->RUN if run; otherwise hold.
REQ-020 In RUN, a frame counter SHALL count frame_start pulses; at count==speed it SHALL reset to 0 and t SHALL advance by step.
REQ-021 In PAUSE, a step pulse SHALL be latched; at the next frame_start t SHALL advance by step once and the latch clear; multiple steps before one frame_start SHALL yield one advance.
REQ-022 Frame counter SHALL hold in IDLE/PAUSE and clear on entering RUN.
REQ-023 Wrap mode: t SHALL change modulo 2^T_W in dir direction; color_idx SHALL increment (mod 8) on each wrap.
REQ-024 Bounce mode: going up, if t+step>max, t SHALL be max and dir flip to down; going down, if t<step, t SHALL be 0 and dir flip to up; color_idx SHALL increment on each flip.
REQ-025 A bounce flip SHALL update the active dir bit only, not shadow; a later shadow copy SHALL overwrite it.
REQ-026 color_idx SHALL load ctrl color base whenever ctrl is copied with a changed color base.
REQ-027 update SHALL pulse exactly on cycles t is written with a different value.

Reset
REQ-028 On rst: state=IDLE, t=0, color_idx=0, update=0, cfg_ready=0, counter=0, step latch=0.
REQ-029 Shadow and active SHALL reset to speed=0, step=1, mask=8'hFF, ctrl=0; xor_mask=8'hFF.
REQ-030 Reset asserted mid-write or mid-advance SHALL discard the operation; cfg_ready SHALL be 1 the first cycle after release.

Configuration
REQ-031 Macro MUNCH_BOUNCE_EN defined: REQ-024/025 behaviour compiled in.
REQ-032 Macro undefined: bounce logic absent, ctrl[1] stored but ignored, always wrap mode.

Structure
REQ-033 Package munch_pkg SHALL hold state enum, register address constants, reset defaults.
REQ-034 Frame prescaler SHALL be sub-module munch_frame_div (counter, speed compare, tick out).

Verification
REQ-035 Reset, run=1, 3 frame_starts -> state RUN after first; t=1 then 2; update pulses twice.
REQ-036 speed=2 written, run=1, 9 frame_starts -> t advances on every 3rd frame after apply.
REQ-037 step=16, t=240, wrap, one advance -> t=0, color_idx+1.
REQ-038 MUNCH_BOUNCE_EN, bounce, step=16, t=250 up -> t=255, dir down; next advance t=239.
REQ-039 run=0 -> PAUSE; three step pulses then frame_start -> t advances once only.
REQ-040 Write mask=8'h0F on frame_start cycle -> xor_mask=8'hFF until next frame_start, then 8'h0F.
